// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-I front end.
// Holds the instruction-fetch state encoding, the default reset PC,
// instruction field positions used by next-PC computation, and the NOP word.
package mips_pkg;

  // Fetch sequencer states: IDLE after reset, REQ while a memory read is
  // outstanding, HOLD while the fetched word waits for downstream.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetchState_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // I-type immediate and J-type target field positions.
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  // All-zero word is sll $0,$0,0, i.e. a NOP.
  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pcPlus4  in  32  PC of the held instruction plus 4
//   instr    in  32  held instruction word
//   jump     in  1   take the J-type target
//   branch   in  1   instruction is a conditional branch
//   zero     in  1   ALU zero flag (branch condition met)
//   nextPc   out 32  selected next PC (jump > taken branch > pcPlus4)
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pcPlus4,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] nextPc
);

  logic [31:0] jumpTarget;
  logic [31:0] branchOffset;
  logic [31:0] branchTarget;
  logic        unusedOpcode;

  // Jump stays inside the current 256 MB region selected by pcPlus4[31:28].
  assign jumpTarget   = {pcPlus4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
  // Sign-extended word offset; the 32-bit add wraps silently by design.
  assign branchOffset = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
  assign branchTarget = pcPlus4 + branchOffset;

  // The opcode field plays no part in target selection here.
  assign unusedOpcode = ^instr[31:26];

  // NOTE: every output of a combinational block gets a default before any
  // branching so no path leaves it unassigned and infers a latch.
  always_comb begin
    nextPc = pcPlus4;
    if (jump) begin
      nextPc = jumpTarget;
    end else if (branch && zero) begin
      nextPc = branchTarget;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Non-pipelined instruction fetch stage.
// Fetches one word per instruction over a req/ack handshake, holds it for the
// control unit until accepted, then loads the next PC from jump/branch results.
// Ports:
//   i_clk, i_rstn        clock (rising edge), synchronous active-low reset
//   o_imemReq/o_imemAddr fetch request and word-aligned address
//   i_imemAck/i_imemData memory response, data valid with ack
//   o_instrCode/o_valid  held instruction and its valid flag
//   i_ready              downstream accepts the held instruction
//   o_pc/o_pcPlus4       PC of the held instruction and PC+4
//   i_jump/i_branch/i_zero  next-PC decisions for the held instruction
module instr_fetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  output logic              o_imemReq,
  output logic [ADDR_W-1:0] o_imemAddr,
  input  logic              i_imemAck,
  input  logic [31:0]       i_imemData,
  output logic [31:0]       o_instrCode,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pcPlus4,
  input  logic              i_jump,
  input  logic              i_branch,
  input  logic              i_zero
);

  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

  fetchState_e       state;
  fetchState_e       stateNext;
  logic [ADDR_W-1:0] fetchPc;     // address of the next/current fetch
  logic [ADDR_W-1:0] heldPc;      // address the held instruction came from
  logic [31:0]       instrCode;
  logic              latchInstr;
  logic              loadPc;
  logic [31:0]       nextPc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext  = state;
    o_imemReq  = 1'b0;
    o_valid    = 1'b0;
    latchInstr = 1'b0;
    loadPc     = 1'b0;
    unique case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        o_imemReq = 1'b1;
        if (i_imemAck) begin
          latchInstr = 1'b1;
          stateNext  = HOLD;
        end
      end
      HOLD: begin
        o_valid = 1'b1;
        if (i_ready) begin
          loadPc    = 1'b1;
          stateNext = REQ;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // o_pc only moves together with o_instrCode so the pair stays coherent.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      fetchPc   <= RESET_PC_ALIGNED;
      heldPc    <= RESET_PC_ALIGNED;
      instrCode <= NOP;
    end else begin
      if (latchInstr) begin
        instrCode <= i_imemData;
        heldPc    <= fetchPc;
      end
      if (loadPc) begin
        fetchPc <= {nextPc[ADDR_W-1:2], 2'b00};
      end
    end
  end

  next_pc_calc u_nextPcCalc (
    .pcPlus4 (o_pcPlus4),
    .instr   (instrCode),
    .jump    (i_jump),
    .branch  (i_branch),
    .zero    (i_zero),
    .nextPc  (nextPc)
  );

  assign o_imemAddr  = fetchPc;
  assign o_instrCode = instrCode;
  assign o_pc        = heldPc;
  assign o_pcPlus4   = heldPc + ADDR_W'(4);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a driver acts as instruction memory and
// downstream consumer, a reference model predicts fetch addresses and held
// instructions, and a monitor compares the DUT against the queued predictions.
module tb_instr_fetch;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        o_imemReq;
  logic [31:0] o_imemAddr;
  logic        i_imemAck = 1'b0;
  logic [31:0] i_imemData = 32'h0;
  logic [31:0] o_instrCode;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_pc;
  logic [31:0] o_pcPlus4;
  logic        i_jump = 1'b0;
  logic        i_branch = 1'b0;
  logic        i_zero = 1'b0;

  always #5 i_clk = ~i_clk;

  instr_fetch dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .o_imemReq   (o_imemReq),
    .o_imemAddr  (o_imemAddr),
    .i_imemAck   (i_imemAck),
    .i_imemData  (i_imemData),
    .o_instrCode (o_instrCode),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_pc        (o_pc),
    .o_pcPlus4   (o_pcPlus4),
    .i_jump      (i_jump),
    .i_branch    (i_branch),
    .i_zero      (i_zero)
  );

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    nChecks++;
    nFails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } held_t;

  held_t       expHeld[$];
  logic [31:0] expAddr[$];
  logic [31:0] modelPc;

  // Next PC from the instruction-set rules, using masks and integer offsets.
  function automatic logic [31:0] refNextPc(input logic [31:0] pc, input logic [31:0] instr,
                                            input bit j, input bit b, input bit z);
    logic [31:0] p4;
    int          off;
    p4 = pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = int'(instr & 32'h0000_FFFF);
      if (off >= 32768) off -= 65536;
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  // ---------------- monitor ----------------
  logic        prevRstn = 1'b0, prevReq = 1'b0, prevAck = 1'b0;
  logic        prevValid = 1'b0, prevReady = 1'b0;
  logic [31:0] lastAddr, lastInstr, lastPc, monAddr;
  held_t       monHeld;

  always @(negedge i_clk) begin
    if (i_rstn && prevRstn) begin
      check("req_valid_exclusive", {31'b0, o_imemReq & o_valid}, 32'h0);
      if (prevReq && prevAck) check("valid_after_ack", {31'b0, o_valid}, 32'h1);
      if (prevValid && prevReady) check("req_after_ready", {31'b0, o_imemReq}, 32'h1);
      if (prevReq && !prevAck) begin
        check("req_stable", {31'b0, o_imemReq}, 32'h1);
        check("addr_stable", o_imemAddr, lastAddr);
      end
      if (prevValid && !prevReady) begin
        check("valid_stable", {31'b0, o_valid}, 32'h1);
        check("instr_stable", o_instrCode, lastInstr);
        check("pc_stable", o_pc, lastPc);
        check("req_low_in_hold", {31'b0, o_imemReq}, 32'h0);
      end
      if (o_imemReq && !prevReq) begin
        if (expAddr.size() == 0) failNow("unexpected_req");
        else begin
          monAddr = expAddr.pop_front();
          check("fetch_addr", o_imemAddr, monAddr);
        end
      end
      if (o_valid && !prevValid) begin
        if (expHeld.size() == 0) failNow("unexpected_valid");
        else begin
          monHeld = expHeld.pop_front();
          check("held_instr", o_instrCode, monHeld.instr);
          check("held_pc", o_pc, monHeld.pc);
          check("held_pc_plus4", o_pcPlus4, monHeld.pc + 32'd4);
        end
      end
    end
    prevRstn  = i_rstn;
    prevReq   = o_imemReq;
    prevAck   = i_imemAck;
    prevValid = o_valid;
    prevReady = i_ready;
    lastAddr  = o_imemAddr;
    lastInstr = o_instrCode;
    lastPc    = o_pc;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic doReset(input bit staleAck);
    i_rstn     = 1'b0;
    i_ready    = 1'b0;
    i_imemAck  = staleAck;
    i_imemData = $urandom;
    tick();
    check("rst_req", {31'b0, o_imemReq}, 32'h0);
    check("rst_valid", {31'b0, o_valid}, 32'h0);
    check("rst_instr", o_instrCode, 32'h0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_pc_plus4", o_pcPlus4, 32'h4);
    tick();
    check("rst_stale_ack_req", {31'b0, o_imemReq}, 32'h0);
    check("rst_stale_ack_valid", {31'b0, o_valid}, 32'h0);
    i_imemAck = 1'b0;
    expHeld.delete();
    expAddr.delete();
    modelPc = 32'h0;
    expAddr.push_back(modelPc);
    i_rstn = 1'b1;
    tick();
    check("first_req_after_release", {31'b0, o_imemReq}, 32'h1);
  endtask

  task automatic waitReq(output bit ok);
    int n = 0;
    while (!o_imemReq && n < 20) begin
      tick();
      n++;
    end
    ok = o_imemReq;
    if (!ok) failNow("timeout_waiting_req");
  endtask

  task automatic fetch(input logic [31:0] instr, input int delay, input int hold,
                       input bit j, input bit b, input bit z);
    bit ok;
    int n;
    waitReq(ok);
    if (!ok) return;
    i_imemAck = 1'b0;
    repeat (delay) tick();
    i_imemAck  = 1'b1;
    i_imemData = instr;
    expHeld.push_back('{instr: instr, pc: modelPc});
    tick();
    i_imemAck  = 1'b0;
    i_imemData = $urandom;
    n = 0;
    while (!o_valid && n < 20) begin
      tick();
      n++;
    end
    if (!o_valid) begin
      failNow("timeout_waiting_valid");
      return;
    end
    // Junk acks and control inputs while holding must be ignored.
    for (int k = 0; k < hold; k++) begin
      i_imemAck  = 1'($urandom_range(0, 1));
      i_imemData = $urandom;
      i_jump     = 1'($urandom_range(0, 1));
      i_branch   = 1'($urandom_range(0, 1));
      i_zero     = 1'($urandom_range(0, 1));
      tick();
    end
    i_imemAck = 1'b0;
    i_jump    = j;
    i_branch  = b;
    i_zero    = z;
    i_ready   = 1'b1;
    modelPc   = refNextPc(modelPc, instr, j, b, z);
    expAddr.push_back(modelPc);
    tick();
    i_ready  = 1'b0;
    i_jump   = 1'($urandom_range(0, 1));
    i_branch = 1'($urandom_range(0, 1));
    i_zero   = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int  t0;
    bit  ok;
    doReset(1'b0);

    // Sequential zero-wait fetch: 0x0, 0x4, 0x8 at two cycles each.
    t0 = cyc;
    for (int k = 0; k < 3; k++) fetch(32'h0000_0020 + 32'(k), 0, 0, 1'b0, 1'b0, 1'b0);
    check("seq_cycles_for_3", 32'(cyc - t0), 32'd6);

    fetch(32'h0800_0040, 0, 0, 1'b1, 1'b0, 1'b0);  // -> 0x100
    fetch(32'h0800_0010, 0, 0, 1'b1, 1'b0, 1'b0);  // -> 0x40
    fetch(32'h0800_0008, 0, 0, 1'b1, 1'b0, 1'b0);  // -> 0x20
    fetch(32'h1000_FFFF, 0, 0, 1'b0, 1'b1, 1'b1);  // taken -> 0x20
    fetch(32'h1000_FFFF, 0, 0, 1'b0, 1'b1, 1'b0);  // not taken -> 0x24
    fetch(32'h0800_0008, 0, 5, 1'b1, 1'b1, 1'b1);  // jump wins -> 0x20
    fetch(32'h1000_FFF6, 3, 0, 1'b0, 1'b1, 1'b1);  // -> 0xFFFF_FFFC
    fetch(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0);  // wraps -> 0x0

    // Reset while a delayed fetch is outstanding, with a stale ack.
    waitReq(ok);
    repeat (3) tick();
    doReset(1'b1);

    for (int k = 0; k < 40; k++) begin
      fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset while holding an instruction.
    waitReq(ok);
    i_imemAck  = 1'b1;
    i_imemData = 32'hDEAD_BEEF;
    expHeld.push_back('{instr: 32'hDEAD_BEEF, pc: modelPc});
    tick();
    i_imemAck = 1'b0;
    tick();
    check("hold_before_reset", {31'b0, o_valid}, 32'h1);
    doReset(1'b0);
    fetch(32'h0000_0020, 0, 1, 1'b0, 1'b0, 1'b0);

    tick();
    check("addr_queue_drained", 32'(expAddr.size()), 32'd0);
    check("held_queue_drained", 32'(expHeld.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage sitting directly upstream of the control unit. Holds the PC and fetches one 32-bit word per instruction from instruction memory over a req/ack handshake. Presents the word on o_instrCode to control and decode, and computes the next PC from the jump/branch decisions fed back by control and the ALU zero flag. Non-pipelined: one instruction in flight, held until downstream accepts it.

Parameters:
ADDR_W, 32, PC and memory address width (fixed 32 for MIPS-I)
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  synchronous reset, active-low
o_imemReq  out  1  fetch request to instruction memory
o_imemAddr  out  32  word address of fetch (PC, bits [1:0] always 0)
i_imemAck  in  1  memory returns data this cycle
i_imemData  in  32  instruction word, valid when i_imemAck=1
o_instrCode  out  32  held instruction to control unit
o_valid  out  1  o_instrCode is valid
i_ready  in  1  downstream consumes held instruction this cycle
o_pc  out  32  PC of held instruction
o_pcPlus4  out  32  o_pc + 4
i_jump  in  1  control o_jump for held instruction
i_branch  in  1  control o_branch for held instruction
i_zero  in  1  ALU zero flag for held instruction

Behaviour:
- Reset (i_rstn=0 at rising edge): state=IDLE, PC=RESET_PC, o_imemReq=0, o_instrCode=0 (NOP), o_valid=0; o_pc=RESET_PC, o_pcPlus4=RESET_PC+4. Reset wins over every other input, including mid-REQ and mid-HOLD; any outstanding fetch is abandoned and a late i_imemAck is ignored.
- States:
  - IDLE: -> REQ unconditionally next cycle, so the first request comes one cycle after reset release.
  - REQ: o_imemReq=1, o_imemAddr=PC. On i_imemAck=1, latch i_imemData into o_instrCode and go to HOLD. Otherwise stay in REQ with the address stable. No timeout.
  - HOLD: o_valid=1, o_imemReq=0. On i_ready=1, sample i_jump/i_branch/i_zero, load the next PC and go to REQ. Otherwise hold all outputs stable.
- Latency: ack cycle N -> o_valid=1 at N+1. i_ready at cycle M -> o_imemReq=1 with the new address at M+1. Minimum 2 cycles per instruction with zero-wait memory.
- Next-PC rule, priority order:
  1. i_jump=1: {pcPlus4[31:28], instr[25:0], 2'b00}.
  2. i_branch & i_zero: pcPlus4 + (sign-extend instr[15:0] << 2).
  3. Otherwise: pcPlus4.
- Jump beats branch when both are set. i_branch=1 with i_zero=0 falls through to pcPlus4.
- Arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0. Negative branch offsets wrap silently. PC[1:0] is forced to 0 on every load.
- i_jump/i_branch/i_zero/i_ready are ignored outside HOLD. i_imemAck is ignored outside REQ.
- o_pc/o_pcPlus4 update only when a new instruction is latched, so they stay coherent with o_instrCode.

Decomposition:
- Package mips_pkg:
  - fetch state enum (IDLE, REQ, HOLD)
  - RESET_PC default
  - instruction field slice constants (IMM [15:0], TARGET [25:0])
  - NOP encoding 32'h0
- Sub-module next_pc_calc: purely combinational. Inputs pcPlus4, instr, jump, branch, zero; output 32-bit next PC. It is unit-testable separately.
- instr_fetch keeps the FSM and registers.

Test Plan:
- Reset release, zero-wait memory (ack same cycle as req), i_ready=1, no branches -> o_imemAddr sequence 0x0, 0x4, 0x8. o_valid pulses every 2nd cycle. First o_imemReq=1 one cycle after i_rstn rises.
- Held instr 0x0800_0010 at o_pc=0x0000_0100, i_jump=1 with i_ready -> next o_imemAddr=0x0000_0040.
- Held instr 0x1000_FFFF at o_pc=0x20, i_branch=1, i_zero=1 -> next addr 0x20. Repeat with i_zero=0 -> 0x24.
- i_jump=1 and i_branch=1, i_zero=1 together -> jump target chosen. Additionally, i_ready=0 for 5 cycles in HOLD -> o_instrCode, o_pc and o_valid stay stable, and o_imemReq stays 0.
- Ack delayed 3 cycles -> o_imemReq and o_imemAddr stay stable until ack. Then i_rstn=0 asserted while in REQ -> next cycle o_valid=0, o_imemReq=0, PC=RESET_PC, and a stale ack arriving during reset is ignored.
- PC=0xFFFF_FFFC, sequential fetch -> next o_imemAddr=0x0000_0000 (wrap).
